// File: rtl/lb_uart_rx.sv
// Oversampled UART receiver: 7/8 data bits, optional odd/even parity, one held byte
// with sticky parity/framing/overrun status cleared by a bus read.
module lb_uart_rx #(
  parameter int unsigned OVS = 16
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       tick,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          par_acc, par_acc_nxt;
  logic          par_bad, par_bad_nxt;
  logic          cfg_bit8, cfg_bit8_nxt;
  logic          cfg_par, cfg_par_nxt;
  logic          cfg_odd, cfg_odd_nxt;
  logic          brk, brk_nxt;
  logic          rx_meta, rx_sync;
  logic [7:0]    rx_data_nxt;
  logic          rx_ready_nxt, parity_err_nxt, frame_err_nxt, overrun_nxt;

  logic          sample_c;
  logic          consume_c;
  logic [7:0]    frame_data_c;
  logic [2:0]    last_bit_c;

  // Bit-sample strobe: half a bit into the start bit, a full bit for every later one
  assign sample_c     = tick && (cnt == ((state == START) ? HALF_LAST : FULL_LAST));
  assign consume_c    = rd && rx_ready;
  assign frame_data_c = cfg_bit8 ? shreg : {1'b0, shreg[7:1]};
  assign last_bit_c   = cfg_bit8 ? 3'd7 : 3'd6;

  // Next-state and datapath
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_cnt_nxt    = bit_cnt;
    shreg_nxt      = shreg;
    par_acc_nxt    = par_acc;
    par_bad_nxt    = par_bad;
    cfg_bit8_nxt   = cfg_bit8;
    cfg_par_nxt    = cfg_par;
    cfg_odd_nxt    = cfg_odd;
    brk_nxt        = brk;
    rx_data_nxt    = rx_data;
    rx_ready_nxt   = rx_ready;
    parity_err_nxt = parity_err;
    frame_err_nxt  = frame_err;
    overrun_nxt    = overrun;

    if (consume_c) begin
      rx_ready_nxt   = 1'b0;
      parity_err_nxt = 1'b0;
      frame_err_nxt  = 1'b0;
      overrun_nxt    = 1'b0;
    end

    if (tick && !sample_c && state != IDLE) begin
      cnt_nxt = cnt + CW'(1);
    end

    case (state)
      IDLE: begin
        cnt_nxt     = '0;
        bit_cnt_nxt = '0;
        // After a framing error the line must go high before a new start counts
        if (brk) begin
          if (rx_sync) brk_nxt = 1'b0;
        end else if (!rx_sync) begin
          state_nxt = START;
        end
      end
      START: begin
        if (sample_c) begin
          cnt_nxt = '0;
          if (rx_sync) begin
            state_nxt = IDLE;
          end else begin
            state_nxt    = DATA;
            shreg_nxt    = '0;
            par_acc_nxt  = 1'b0;
            par_bad_nxt  = 1'b0;
            cfg_bit8_nxt = bit8;
            cfg_par_nxt  = parity_en;
            cfg_odd_nxt  = odd_n_even;
          end
        end
      end
      DATA: begin
        if (sample_c) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx_sync, shreg[7:1]};
          par_acc_nxt = par_acc ^ rx_sync;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == last_bit_c) state_nxt = cfg_par ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (sample_c) begin
          cnt_nxt     = '0;
          par_bad_nxt = ((par_acc ^ rx_sync) != cfg_odd);
          state_nxt   = STOP;
        end
      end
      STOP: begin
        if (sample_c) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
          brk_nxt   = !rx_sync;
          if (!rx_ready || rd) begin
            rx_data_nxt    = frame_data_c;
            rx_ready_nxt   = 1'b1;
            parity_err_nxt = parity_err_nxt | par_bad;
            frame_err_nxt  = frame_err_nxt | !rx_sync;
          end else begin
            overrun_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      par_bad    <= 1'b0;
      cfg_bit8   <= 1'b0;
      cfg_par    <= 1'b0;
      cfg_odd    <= 1'b0;
      brk        <= 1'b0;
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_data    <= '0;
      rx_ready   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_cnt    <= bit_cnt_nxt;
      shreg      <= shreg_nxt;
      par_acc    <= par_acc_nxt;
      par_bad    <= par_bad_nxt;
      cfg_bit8   <= cfg_bit8_nxt;
      cfg_par    <= cfg_par_nxt;
      cfg_odd    <= cfg_odd_nxt;
      brk        <= brk_nxt;
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_data    <= rx_data_nxt;
      rx_ready   <= rx_ready_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      overrun    <= overrun_nxt;
    end
  end

endmodule

// File: doc/lb_uart_rx.md
LB_UART_RX -- requirements
Module: lb_uart_rx

Interface
REQ-001 SHALL have parameter OVS, default 16, giving oversample ticks per bit; mid-bit point is OVS/2.
REQ-002 SHALL have port clk  input  1  sole clock; all state is updated on its rising edge.
REQ-003 SHALL have port resetb  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port tick  input  1  one-clk enable pulse at OVS x baud rate, from the baud generator.
REQ-005 SHALL have port rx  input  1  asynchronous serial line; idles high.
REQ-006 SHALL have port bit8  input  1  1 = 8 data bits; 0 = 7 data bits.
REQ-007 SHALL have port parity_en  input  1  1 = a parity bit follows the data bits.
REQ-008 SHALL have port odd_n_even  input  1  1 = odd parity; 0 = even parity.
REQ-009 SHALL have port rd  input  1  one-clk bus read strobe that consumes the held byte.
REQ-010 SHALL have port rx_data  output  8  held received byte.
REQ-011 SHALL have port rx_ready  output  1  held byte is valid and unread.
REQ-012 SHALL have ports parity_err, frame_err, overrun  output  1 each  sticky status flags.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer; only the synchronized value is used anywhere.
REQ-014 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-015 SHALL, in IDLE, move to START when synchronized rx is 0, and clear the tick counter.
REQ-016 SHALL, in START, sample rx at tick count OVS/2; rx=1 returns to IDLE with no flags set (false start); rx=0 moves to DATA.
REQ-017 SHALL latch bit8, parity_en and odd_n_even at start confirmation; changes to them mid-frame have no effect on the current frame.
REQ-018 SHALL sample each later bit once, OVS ticks after the previous sample, counting only on tick=1.
REQ-019 SHALL shift data LSB first: 8 bits when bit8=1, 7 bits when bit8=0, with bit 7 forced to 0 for 7-bit frames.
REQ-020 SHALL go from DATA to PARITY when parity_en=1, and to STOP otherwise.
REQ-021 SHALL compute parity as the XOR of the data bits and the parity bit; for even parity the result must be 0, for odd parity it must be 1; a mismatch marks the frame parity-bad.
REQ-022 SHALL treat stop bit = 0 as a framing error for that frame.
REQ-023 SHALL, at the STOP sample with rx_ready=0 or rd=1 in the same cycle, load rx_data, set rx_ready=1, OR the frame's errors into parity_err/frame_err, and return to IDLE.
REQ-024 SHALL, at the STOP sample with rx_ready=1 and rd=0, drop the new byte, keep rx_data unchanged, set overrun=1, and return to IDLE.
REQ-025 SHALL, on rd=1 with no simultaneous load, clear rx_ready, parity_err, frame_err and overrun on the next edge; rx_data keeps its value.
REQ-026 SHALL make rd=1 while rx_ready=0 a no-op.
REQ-027 SHALL, after a frame_err frame, return to IDLE and require rx to be seen high before a new start is detected (no false start during a break).
REQ-028 SHALL have a latency of exactly 1 clk from the STOP-sample tick to rx_ready=1.

Reset
REQ-029 SHALL, when resetb=0, asynchronously force FSM=IDLE, counters=0, synchronizer=11, rx_data=0x00, and rx_ready, parity_err, frame_err, overrun all 0.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame; the first frame after release is received normally.

Verification
REQ-031 SHALL pass: bit8=1, parity off, send 0xA5 -> rx_data=0xA5, rx_ready=1, all flags 0; rd -> rx_ready=0.
REQ-032 SHALL pass: bit8=0, parity_en=1, odd, send 0x41 with parity bit 1 -> rx_data=0x41, parity_err=0; repeat with parity bit 0 -> parity_err=1.
REQ-033 SHALL pass: 8N1 send 0x3C with stop=0 -> rx_data=0x3C, frame_err=1; rx held low for 3 bit times -> no further frame until rx returns high.
REQ-034 SHALL pass: send 0x11, then 0x22 with no rd -> rx_data=0x11, overrun=1; second case with rd coincident with the 0x22 STOP sample -> rx_data=0x22, rx_ready=1, overrun=0.
REQ-035 SHALL pass: rx low pulse of OVS/4 ticks -> FSM back in IDLE, rx_ready=0; resetb pulsed low during DATA bit 3 -> all outputs 0, and the next 0x5A frame is received correctly.
